// File: rtl/uart_dbg_pkg.sv
// Shared constants, state encoding and helpers for the UART debug command sequencer.
// UART_DBG_WR_ACK_EN adds the ACK state and the ACK/NACK reply bytes.
package uart_dbg_pkg;

   localparam logic [7:0]  MAGIC       = 8'hCC;
   localparam logic [6:0]  CMD_OP      = 7'h06;
   localparam logic [7:0]  ACK_BYTE    = 8'hA5;
   localparam logic [7:0]  NACK_BYTE   = 8'hEE;
   localparam int          FRAME_LEN   = 7;
   localparam int          DATA_BYTES  = FRAME_LEN - 3;
   localparam logic [13:0] BYTE_TO     = 14'd8680;
   localparam logic [7:0]  RD_TO       = 8'd255;
   localparam logic [31:0] RD_ERR_DATA = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      HUNT,
      CMD,
      ADDR,
      DATA,
      WR,
      RD,
`ifdef UART_DBG_WR_ACK_EN
      RSP,
      ACK
`else
      RSP
`endif
   } state_t;

   function automatic logic [7:0] sat_inc(input logic [7:0] value);
      return (value == 8'hFF) ? value : value + 8'd1;
   endfunction

endpackage

// File: rtl/uart_dbg_cmd_ctrl_if.sv
// Byte-stream and register-bus signals of the UART debug command sequencer.
// master is the sequencer side; slave is the UART/register-bus side.
interface uart_dbg_cmd_ctrl_if;

   logic [7:0]  rx_byte;
   logic        rx_valid;
   logic [7:0]  tx_byte;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  u_reg_addr;
   logic [31:0] u_reg_wr_data;
   logic        u_reg_wr_en;
   logic        u_reg_rd_en;
   logic [31:0] u_reg_rd_data;
   logic        u_reg_rd_done;

   modport master (
      input  rx_byte, rx_valid, tx_ready, u_reg_rd_data, u_reg_rd_done,
      output tx_byte, tx_valid, u_reg_addr, u_reg_wr_data, u_reg_wr_en, u_reg_rd_en
   );

   modport slave (
      output rx_byte, rx_valid, tx_ready, u_reg_rd_data, u_reg_rd_done,
      input  tx_byte, tx_valid, u_reg_addr, u_reg_wr_data, u_reg_wr_en, u_reg_rd_en
   );

endinterface

// File: rtl/uart_dbg_tx_ser.sv
// Serialises up to four bytes of a 32-bit word, MSB first, over a valid/ready handshake.
// A load arms the shifter; done pulses on the accept of the final byte.
module uart_dbg_tx_ser (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [31:0] word,
   input  logic [2:0]  count,
   input  logic        tx_ready,
   output logic [7:0]  tx_byte,
   output logic        tx_valid,
   output logic        done
);

   logic [31:0] shift_q;
   logic [2:0]  left_q;

   // The byte on offer stays put until it is accepted, then the next one moves up.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_q <= '0;
         left_q  <= '0;
      end else if (load) begin
         shift_q <= word;
         left_q  <= count;
      end else if (tx_valid && tx_ready) begin
         shift_q <= {shift_q[23:0], 8'h00};
         left_q  <= left_q - 3'd1;
      end
   end

   assign tx_valid = (left_q != 3'd0);
   assign tx_byte  = shift_q[31:24];
   assign done     = tx_valid && tx_ready && (left_q == 3'd1);

endmodule

// File: rtl/uart_dbg_cmd_ctrl.sv
// Parses 7-byte debug frames from the UART RX stream into register writes/reads
// and returns read data on TX. UART_DBG_WR_ACK_EN adds a one-byte write/bad-cmd reply.
module uart_dbg_cmd_ctrl
   import uart_dbg_pkg::*;
(
   input  logic                clk_25mhz,
   input  logic                core_reset,
   uart_dbg_cmd_ctrl_if.master bus,
   output logic                busy,
   output logic                err_pulse,
   output logic [7:0]          err_cnt
);

   state_t      state_q, next_state;
   logic        cmd_read_q;
   logic        bad_cmd_q;
   logic [1:0]  idx_q;
   logic [31:0] data_q;
   logic [13:0] gap_cnt_q;
   logic [7:0]  rd_cnt_q;
   logic [31:0] rsp_word_q;
   logic        tx_loaded_q;
   logic [7:0]  addr_q;
   logic [31:0] wr_data_q;
   logic        err_pulse_q;
   logic [7:0]  err_cnt_q;

   logic        err_event;
   logic        gap_expired;
   logic        rd_expired;
   logic        last_data;
   logic        tx_phase;
   logic        ser_load;
   logic [2:0]  ser_count;
   logic        ser_done;

   // A byte arriving on the expiry cycle wins, so expiry also requires an idle rx.
   assign gap_expired = (gap_cnt_q == BYTE_TO) && !bus.rx_valid;
   assign rd_expired  = (rd_cnt_q == RD_TO - 8'd1);
   assign last_data   = bus.rx_valid && (idx_q == 2'(DATA_BYTES - 1));

`ifdef UART_DBG_WR_ACK_EN
   assign tx_phase  = (state_q == RSP) || (state_q == ACK);
   assign ser_count = (state_q == RSP) ? 3'(DATA_BYTES) : 3'd1;
`else
   assign tx_phase  = (state_q == RSP);
   assign ser_count = 3'(DATA_BYTES);
`endif

   assign ser_load = tx_phase && !tx_loaded_q;

   always_ff @(posedge clk_25mhz or posedge core_reset) begin
      if (core_reset) begin
         state_q <= HUNT;
      end else begin
         state_q <= next_state;
      end
   end

   // Next-state and error decisions for the frame sequencer.
   always_comb begin
      next_state = state_q;
      err_event  = 1'b0;
      case (state_q)
         HUNT: begin
            if (bus.rx_valid && (bus.rx_byte == MAGIC)) begin
               next_state = CMD;
            end
         end
         CMD: begin
            if (bus.rx_valid) begin
               next_state = ADDR;
            end else if (gap_expired) begin
               next_state = HUNT;
               err_event  = 1'b1;
            end
         end
         ADDR: begin
            if (bus.rx_valid) begin
               next_state = DATA;
            end else if (gap_expired) begin
               next_state = HUNT;
               err_event  = 1'b1;
            end
         end
         DATA: begin
            if (last_data) begin
               if (bad_cmd_q) begin
                  err_event = 1'b1;
`ifdef UART_DBG_WR_ACK_EN
                  next_state = ACK;
`else
                  next_state = HUNT;
`endif
               end else if (cmd_read_q) begin
                  next_state = RD;
               end else begin
                  next_state = WR;
               end
            end else if (gap_expired) begin
               next_state = HUNT;
               err_event  = 1'b1;
            end
         end
         WR: begin
            err_event = bus.rx_valid;
`ifdef UART_DBG_WR_ACK_EN
            next_state = ACK;
`else
            next_state = HUNT;
`endif
         end
         RD: begin
            err_event = bus.rx_valid;
            if (bus.u_reg_rd_done) begin
               next_state = RSP;
            end else if (rd_expired) begin
               next_state = RSP;
               err_event  = 1'b1;
            end
         end
         RSP: begin
            err_event = bus.rx_valid;
            if (ser_done) begin
               next_state = HUNT;
            end
         end
`ifdef UART_DBG_WR_ACK_EN
         ACK: begin
            err_event = bus.rx_valid;
            if (ser_done) begin
               next_state = HUNT;
            end
         end
`endif
         default: begin
            next_state = HUNT;
         end
      endcase
   end

   // Frame capture, timeout counters, response word and error bookkeeping.
   always_ff @(posedge clk_25mhz or posedge core_reset) begin
      if (core_reset) begin
         cmd_read_q  <= 1'b0;
         bad_cmd_q   <= 1'b0;
         idx_q       <= '0;
         data_q      <= '0;
         gap_cnt_q   <= '0;
         rd_cnt_q    <= '0;
         rsp_word_q  <= '0;
         tx_loaded_q <= 1'b0;
         addr_q      <= '0;
         wr_data_q   <= '0;
         err_pulse_q <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         err_pulse_q <= err_event;
         if (err_event) begin
            err_cnt_q <= sat_inc(err_cnt_q);
         end

         if (bus.rx_valid) begin
            gap_cnt_q <= 14'd1;
         end else if (gap_cnt_q != BYTE_TO) begin
            gap_cnt_q <= gap_cnt_q + 14'd1;
         end

         if ((state_q == CMD) && bus.rx_valid) begin
            cmd_read_q <= bus.rx_byte[7];
            bad_cmd_q  <= (bus.rx_byte[6:0] != CMD_OP);
         end

         if ((state_q == ADDR) && bus.rx_valid) begin
            addr_q <= bus.rx_byte;
            idx_q  <= '0;
         end

         if ((state_q == DATA) && bus.rx_valid) begin
            data_q <= {data_q[23:0], bus.rx_byte};
            idx_q  <= idx_q + 2'd1;
         end

         if ((state_q == DATA) && (next_state == WR)) begin
            wr_data_q <= {data_q[23:0], bus.rx_byte};
         end

         rd_cnt_q <= (state_q == RD) ? rd_cnt_q + 8'd1 : 8'd0;

         if ((state_q == RD) && (next_state == RSP)) begin
            rsp_word_q <= bus.u_reg_rd_done ? bus.u_reg_rd_data : RD_ERR_DATA;
         end
`ifdef UART_DBG_WR_ACK_EN
         else if ((next_state == ACK) && (state_q != ACK)) begin
            rsp_word_q <= {(state_q == WR) ? ACK_BYTE : NACK_BYTE, 24'h000000};
         end
`endif

         tx_loaded_q <= tx_phase;
      end
   end

   uart_dbg_tx_ser u_tx_ser (
      .clk      (clk_25mhz),
      .rst      (core_reset),
      .load     (ser_load),
      .word     (rsp_word_q),
      .count    (ser_count),
      .tx_ready (bus.tx_ready),
      .tx_byte  (bus.tx_byte),
      .tx_valid (bus.tx_valid),
      .done     (ser_done)
   );

   assign bus.u_reg_addr    = addr_q;
   assign bus.u_reg_wr_data = wr_data_q;
   assign bus.u_reg_wr_en   = (state_q == WR);
   assign bus.u_reg_rd_en   = (state_q == RD);
   assign busy              = (state_q != HUNT);
   assign err_pulse         = err_pulse_q;
   assign err_cnt           = err_cnt_q;

endmodule

// File: tb/tb_uart_dbg_cmd_ctrl.sv
// Directed self-checking bench for uart_dbg_cmd_ctrl (default build, no write ACK).
// Frames, read responses, timeouts, resync and asynchronous reset are exercised.
module tb_uart_dbg_cmd_ctrl;

   logic       clk_25mhz = 1'b0;
   logic       core_reset;
   logic       busy;
   logic       err_pulse;
   logic [7:0] err_cnt;

   int checks    = 0;
   int errors    = 0;
   int wr_pulses = 0;
   int tx_cycles = 0;

   uart_dbg_cmd_ctrl_if bus_if ();

   uart_dbg_cmd_ctrl dut (
      .clk_25mhz  (clk_25mhz),
      .core_reset (core_reset),
      .bus        (bus_if),
      .busy       (busy),
      .err_pulse  (err_pulse),
      .err_cnt    (err_cnt)
   );

   always #20 clk_25mhz = ~clk_25mhz;

   // Count write strobes and offered TX bytes on the falling edge.
   always @(negedge clk_25mhz) begin
      if (bus_if.u_reg_wr_en) wr_pulses++;
      if (bus_if.tx_valid) tx_cycles++;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk_25mhz);
      #1;
   endtask

   task automatic apply_stimulus(input logic [7:0] b);
      bus_if.rx_byte  = b;
      bus_if.rx_valid = 1'b1;
      @(posedge clk_25mhz);
      #1;
      bus_if.rx_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [55:0] frame);
      for (int i = 6; i >= 0; i--) apply_stimulus(frame[i*8 +: 8]);
   endtask

   task automatic recv_word(input logic [31:0] word, input int stall_idx);
      logic [7:0] eb;
      int         waited;
      for (int i = 0; i < 4; i++) begin
         eb     = 8'(word >> (24 - 8*i));
         waited = 0;
         while (!bus_if.tx_valid && waited < 20) begin
            step(1);
            waited++;
         end
         check_output("tx_valid", 32'(bus_if.tx_valid), 32'd1);
         check_output("tx_byte", 32'(bus_if.tx_byte), 32'(eb));
         if (i == stall_idx) begin
            step(5);
            check_output("tx_byte_stall", 32'(bus_if.tx_byte), 32'(eb));
            check_output("tx_valid_stall", 32'(bus_if.tx_valid), 32'd1);
         end
         bus_if.tx_ready = 1'b1;
         step(1);
         bus_if.tx_ready = 1'b0;
      end
   endtask

   initial begin
      int wr0;
      int tx0;
      int n;

      core_reset           = 1'b1;
      bus_if.rx_byte       = 8'h00;
      bus_if.rx_valid      = 1'b0;
      bus_if.tx_ready      = 1'b0;
      bus_if.u_reg_rd_data = 32'h0;
      bus_if.u_reg_rd_done = 1'b0;
      step(3);
      check_output("rst_busy", 32'(busy), 32'd0);
      check_output("rst_tx_valid", 32'(bus_if.tx_valid), 32'd0);
      check_output("rst_wr_en", 32'(bus_if.u_reg_wr_en), 32'd0);
      check_output("rst_rd_en", 32'(bus_if.u_reg_rd_en), 32'd0);
      check_output("rst_err_cnt", 32'(err_cnt), 32'd0);
      core_reset = 1'b0;
      step(2);

      // Write frame
      wr0 = wr_pulses;
      tx0 = tx_cycles;
      send_frame(56'hCC06A2DEADDEAD);
      check_output("wr_en", 32'(bus_if.u_reg_wr_en), 32'd1);
      check_output("wr_addr", 32'(bus_if.u_reg_addr), 32'h0000_00A2);
      check_output("wr_data", bus_if.u_reg_wr_data, 32'hDEADDEAD);
      step(1);
      check_output("wr_en_drop", 32'(bus_if.u_reg_wr_en), 32'd0);
      check_output("wr_busy_done", 32'(busy), 32'd0);
      check_output("wr_pulse_count", 32'(wr_pulses - wr0), 32'd1);
      check_output("wr_no_tx", 32'(tx_cycles - tx0), 32'd0);
      check_output("wr_err_cnt", 32'(err_cnt), 32'd0);

      // Read frame with rd_done one cycle after rd_en, stall on byte 2
      send_frame(56'hCC861000000000);
      check_output("rd_en", 32'(bus_if.u_reg_rd_en), 32'd1);
      check_output("rd_addr", 32'(bus_if.u_reg_addr), 32'h0000_0010);
      step(1);
      bus_if.u_reg_rd_data = 32'hAAAADDDD;
      bus_if.u_reg_rd_done = 1'b1;
      check_output("rd_en_at_done", 32'(bus_if.u_reg_rd_en), 32'd1);
      step(1);
      bus_if.u_reg_rd_done = 1'b0;
      bus_if.u_reg_rd_data = 32'h0;
      check_output("rd_en_drop", 32'(bus_if.u_reg_rd_en), 32'd0);
      check_output("rsp_entry_tx_valid", 32'(bus_if.tx_valid), 32'd0);
      recv_word(32'hAAAADDDD, 1);
      step(1);
      check_output("rsp_busy_done", 32'(busy), 32'd0);
      check_output("rsp_tx_idle", 32'(bus_if.tx_valid), 32'd0);
      check_output("wr_data_held", bus_if.u_reg_wr_data, 32'hDEADDEAD);
      check_output("rd_err_cnt", 32'(err_cnt), 32'd0);

      // Read timeout
      send_frame(56'hCC861000000000);
      n = 0;
      while (bus_if.u_reg_rd_en && n < 400) begin
         n++;
         step(1);
      end
      check_output("rdto_rd_en_cycles", 32'(n), 32'd255);
      check_output("rdto_err_pulse", 32'(err_pulse), 32'd1);
      check_output("rdto_err_cnt", 32'(err_cnt), 32'd1);
      recv_word(32'hFFFFFFFF, -1);
      step(1);
      check_output("rdto_busy_done", 32'(busy), 32'd0);

      // Garbage then bad command
      wr0 = wr_pulses;
      apply_stimulus(8'h11);
      apply_stimulus(8'h22);
      check_output("garbage_busy", 32'(busy), 32'd0);
      check_output("garbage_err_cnt", 32'(err_cnt), 32'd1);
      send_frame(56'hCC070001020304);
      check_output("badcmd_err_pulse", 32'(err_pulse), 32'd1);
      check_output("badcmd_busy", 32'(busy), 32'd0);
      check_output("badcmd_err_cnt", 32'(err_cnt), 32'd2);
      check_output("badcmd_rd_en", 32'(bus_if.u_reg_rd_en), 32'd0);
      step(1);
      check_output("badcmd_err_pulse_drop", 32'(err_pulse), 32'd0);
      check_output("badcmd_no_write", 32'(wr_pulses - wr0), 32'd0);
      send_frame(56'hCC065501020304);
      check_output("resync_wr_en", 32'(bus_if.u_reg_wr_en), 32'd1);
      check_output("resync_addr", 32'(bus_if.u_reg_addr), 32'h0000_0055);
      check_output("resync_data", bus_if.u_reg_wr_data, 32'h01020304);
      step(1);

      // Inter-byte timeout: still in frame at BYTE_TO, aborted one cycle later
      apply_stimulus(8'hCC);
      apply_stimulus(8'h06);
      apply_stimulus(8'hA2);
      step(8679);
      check_output("gap_busy_at_limit", 32'(busy), 32'd1);
      step(1);
      check_output("gap_busy_after", 32'(busy), 32'd0);
      check_output("gap_err_pulse", 32'(err_pulse), 32'd1);
      check_output("gap_err_cnt", 32'(err_cnt), 32'd3);

      // A byte landing exactly on the expiry cycle keeps the frame alive
      apply_stimulus(8'hCC);
      apply_stimulus(8'h06);
      step(8679);
      apply_stimulus(8'hA2);
      apply_stimulus(8'hDE);
      apply_stimulus(8'hAD);
      apply_stimulus(8'hBE);
      apply_stimulus(8'hEF);
      check_output("gap_edge_wr_en", 32'(bus_if.u_reg_wr_en), 32'd1);
      check_output("gap_edge_data", bus_if.u_reg_wr_data, 32'hDEADBEEF);
      check_output("gap_edge_err_cnt", 32'(err_cnt), 32'd3);
      step(1);

      // Asynchronous reset while a read is outstanding
      send_frame(56'hCC862000000000);
      check_output("mid_rd_en", 32'(bus_if.u_reg_rd_en), 32'd1);
      #5 core_reset = 1'b1;
      #1;
      check_output("arst_rd_en", 32'(bus_if.u_reg_rd_en), 32'd0);
      check_output("arst_busy", 32'(busy), 32'd0);
      check_output("arst_addr", 32'(bus_if.u_reg_addr), 32'd0);
      check_output("arst_wr_data", bus_if.u_reg_wr_data, 32'd0);
      check_output("arst_err_cnt", 32'(err_cnt), 32'd0);
      step(2);
      core_reset = 1'b0;
      step(5);
      check_output("post_rst_tx_valid", 32'(bus_if.tx_valid), 32'd0);
      check_output("post_rst_busy", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
